// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit FIFO slice.
package uart_pkg;

   localparam int unsigned FIFO_DEPTH  = 16;
   localparam int unsigned FIFO_ADDR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with registered occupancy flags and sticky overflow.
module uart_sync_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              flush,
   input  logic              pop,
   input  logic              ovf_clr,
   output logic [7:0]        rd_data_c,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              ovf_q, ovf_d;
   logic              push_c;
   logic              drop_c;

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   always_comb begin
      push_c   = wr_en && !flush && (!full_q || pop);
      drop_c   = wr_en && !flush && full_q && !pop;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (drop_c)  ovf_d = 1'b1;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) wr_ptr_d = ADDR_W'(wr_ptr_q + 1'b1);
         if (pop)    rd_ptr_d = ADDR_W'(rd_ptr_q + 1'b1);
         case ({push_c, pop})
            2'b10:   count_d = (ADDR_W+1)'(count_q + 1'b1);
            2'b01:   count_d = (ADDR_W+1)'(count_q - 1'b1);
            default: count_d = count_q;
         endcase
      end
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data_c = mem_q[rd_ptr_q];
   assign full      = full_q;
   assign empty     = empty_q;
   assign level     = count_q;
   assign overflow  = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO plus launch FSM feeding the UART serialiser.
// Optional UART_TX_FIFO_THRESH_IRQ_EN adds a level-threshold interrupt.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [7:0]      wr_data,
   input  logic            flush,
   input  logic            tx_en,
   input  logic            ovf_clr,
   output logic            full,
   output logic            empty,
   output logic [ADDR_W:0] level,
   output logic            overflow,
   output logic            tx_start,
   output logic [7:0]      tx_data,
   input  logic            tx_busy
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
   ,
   input  logic [ADDR_W:0] thresh,
   output logic            irq_thresh
`endif
);

   tx_state_e  state_q, state_d;
   logic       tx_start_q, tx_start_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       pop_c;
   logic [7:0] rd_data_c;
   logic       empty_w;

   uart_sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .flush     (flush),
      .pop       (pop_c),
      .ovf_clr   (ovf_clr),
      .rd_data_c (rd_data_c),
      .full      (full),
      .empty     (empty_w),
      .level     (level),
      .overflow  (overflow)
   );

   // Launch FSM: pop and capture the head byte only on IDLE->LAUNCH.
   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      pop_c      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty_w && tx_en && !tx_busy) begin
               state_d    = LAUNCH;
               tx_start_d = 1'b1;
               tx_data_d  = rd_data_c;
               pop_c      = 1'b1;
            end
         end
         LAUNCH:    state_d = WAIT_DONE;
         WAIT_DONE: if (!tx_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign empty    = empty_w;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_THRESH_IRQ_EN
   logic irq_q, irq_d;

   // Suppressed while a flush is being applied so a stale level cannot fire.
   always_comb begin
      irq_d = (level <= thresh) && !flush;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_q <= 1'b0;
      else        irq_q <= irq_d;
   end

   assign irq_thresh = irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a simple busy-counter transmitter model.
module tb_uart_tx_fifo;

   localparam int unsigned ADDR_W   = 4;
   localparam int          BAUD_DIV = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            wr_en = 1'b0;
   logic [7:0]      wr_data = 8'h00;
   logic            flush = 1'b0;
   logic            tx_en = 1'b0;
   logic            ovf_clr = 1'b0;
   logic            full;
   logic            empty;
   logic [ADDR_W:0] level;
   logic            overflow;
   logic            tx_start;
   logic [7:0]      tx_data;
   logic            tx_busy;
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
   logic [ADDR_W:0] thresh = 5'd4;
   logic            irq_thresh;
`endif

   uart_tx_fifo dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .flush    (flush),
      .tx_en    (tx_en),
      .ovf_clr  (ovf_clr),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy)
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
      ,
      .thresh     (thresh),
      .irq_thresh (irq_thresh)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: busy rises on the edge that samples tx_start.
   int busy_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)            busy_cnt <= 0;
      else if (tx_start)     busy_cnt <= BAUD_DIV;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   logic [7:0] exp_q[$];
   int  n_checks = 0;
   int  n_pass = 0;
   bit  gap_chk = 1'b0;
   int  fall_cyc = -100;
   bit  prev_busy = 1'b0;
   bit  prev_start = 1'b0;
   logic [7:0] mon_exp;
   bit  mon_ok;

   // Monitor: every launch pops the scoreboard and is checked.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_busy && !tx_busy) fall_cyc = cyc;
         if (tx_start) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL launch: unexpected tx_start tx_data=%0h, required no launch", tx_data);
            end else begin
               mon_exp = exp_q.pop_front();
               mon_ok  = (tx_data == mon_exp) && !tx_busy && !prev_start &&
                         (!gap_chk || (cyc - fall_cyc) == 2);
               if (mon_ok) n_pass++;
               else $display("FAIL launch: tx_data=%0h busy=%0b prev_start=%0b gap=%0d, required data=%0h busy=0 prev_start=0 gap=2",
                             tx_data, tx_busy, prev_start, cyc - fall_cyc, mon_exp);
            end
         end
      end
      prev_busy  = tx_busy;
      prev_start = tx_start;
   end

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d, input bit expect_tx);
      wr_en   = 1'b1;
      wr_data = d;
      if (expect_tx) exp_q.push_back(d);
      tick();
   endtask

   task automatic drain(input string name, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      repeat (8) tick();
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);

      // Single byte latency.
      tx_en = 1'b1;
      push_byte(8'hA5, 1'b1);
      wr_en = 1'b0;
      check("t1_empty_after_write", empty, 0);
      check("t1_no_start_yet", tx_start, 0);
      tick();
      check("t1_start", tx_start, 1);
      check("t1_data", tx_data, 8'hA5);
      tick();
      check("t1_start_pulse_end", tx_start, 0);
      check("t1_empty_after", empty, 1);
      drain("t1_drain", 20);

      // Back-to-back characters, gap checked from the second launch on.
      for (int i = 1; i <= 4; i++) push_byte(8'(i), 1'b1);
      wr_en   = 1'b0;
      gap_chk = 1'b1;
      drain("t2_drain", 100);
      gap_chk = 1'b0;

      // Fill with launch held, then overflow.
      tx_en = 1'b0;
      for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), 1'b1);
      wr_en = 1'b0;
      check("t3_full", full, 1);
      check("t3_level", level, 16);
      check("t3_ovf_before", overflow, 0);
      push_byte(8'hEE, 1'b0);
      wr_en = 1'b0;
      check("t3_ovf_set", overflow, 1);
      check("t3_level_drop", level, 16);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("t3_ovf_clr", overflow, 0);
      tx_en = 1'b1;
      drain("t3_drain", 300);
      check("t3_level_end", level, 0);
      check("t3_empty_end", empty, 1);

      // Write into a full FIFO on the same edge as a pop.
      tx_en = 1'b0;
      for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i), 1'b1);
      wr_en = 1'b0;
      check("t4_full", full, 1);
      tx_en = 1'b1;
      push_byte(8'h40, 1'b1);
      wr_en = 1'b0;
      check("t4_level", level, 16);
      check("t4_ovf", overflow, 0);
      check("t4_full_after", full, 1);
      drain("t4_drain", 300);

      // Flush during WAIT_DONE.
      tx_en = 1'b0;
      push_byte(8'h50, 1'b1);
      for (int i = 1; i < 6; i++) push_byte(8'(8'h50 + i), 1'b0);
      wr_en = 1'b0;
      check("t5_level6", level, 6);
      tx_en = 1'b1;
      tick();
      tick();
      check("t5_level5", level, 5);
      check("t5_busy", tx_busy, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5_level_flush", level, 0);
      check("t5_empty_flush", empty, 1);
      check("t5_ovf_kept", overflow, 0);
      repeat (30) tick();
      check("t5_scoreboard", exp_q.size(), 0);
      check("t5_busy_done", tx_busy, 0);

      // Asynchronous reset during WAIT_DONE.
      tx_en = 1'b0;
      push_byte(8'h60, 1'b1);
      for (int i = 1; i < 4; i++) push_byte(8'(8'h60 + i), 1'b0);
      wr_en = 1'b0;
      tx_en = 1'b1;
      tick();
      tick();
      check("t6_level3", level, 3);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_level", level, 0);
      check("t6_rst_empty", empty, 1);
      check("t6_rst_full", full, 0);
      check("t6_rst_ovf", overflow, 0);
      check("t6_rst_start", tx_start, 0);
      check("t6_rst_data", tx_data, 8'h00);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (30) tick();
      check("t6_level_end", level, 0);
      check("t6_scoreboard", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
